// File: rtl/tcam_pkg.sv
// Shared encodings for the TCAM lookup arbiter: controller modes, config opcodes, FSM states.
package tcam_pkg;

  localparam logic [2:0] MODE_I   = 3'b000;
  localparam logic [2:0] MODE_W   = 3'b001;
  localparam logic [2:0] MODE_R   = 3'b010;
  localparam logic [2:0] MODE_F   = 3'b011;
  localparam logic [2:0] MODE_C   = 3'b100;
  localparam logic [2:0] MODE_RST = 3'b101;

  localparam logic CFG_WRITE = 1'b0;
  localparam logic CFG_FLUSH = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMP_WAIT,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/tcam_lookup_arbiter_if.sv
// Signal bundle between the lookup requesters / config master / TCAM controller and the arbiter.
interface tcam_lookup_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 4,
  parameter int BITS    = 8
);
  localparam int PORT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*ID_W-1:0] req_id;

  logic                    cfg_valid;
  logic                    cfg_ready;
  logic                    cfg_op;
  logic [ADDR_W-1:0]       cfg_addr;
  logic [BITS-1:0]         cfg_data;
  logic [BITS-1:0]         cfg_mskb;
  logic                    cfg_vbi;

  logic [2:0]              tcam_mode;
  logic [ID_W-1:0]         tcam_pkt_id;
  logic [ADDR_W-1:0]       tcam_addr;
  logic [BITS-1:0]         tcam_data;
  logic [BITS-1:0]         tcam_mskb;
  logic                    tcam_vbi;
  logic                    tcam_vbe;
  logic                    tcam_dcs;
  logic [ID_W-1:0]         tcam_dst_id;

  logic                    rsp_valid;
  logic [PORT_W-1:0]       rsp_port;
  logic [ID_W-1:0]         rsp_dst;
  logic                    busy;

  modport slave (
    input  req_valid, req_id,
    input  cfg_valid, cfg_op, cfg_addr, cfg_data, cfg_mskb, cfg_vbi,
    input  tcam_dst_id,
    output req_ready, cfg_ready,
    output tcam_mode, tcam_pkt_id, tcam_addr, tcam_data, tcam_mskb, tcam_vbi, tcam_vbe, tcam_dcs,
    output rsp_valid, rsp_port, rsp_dst, busy
  );

  modport master (
    output req_valid, req_id,
    output cfg_valid, cfg_op, cfg_addr, cfg_data, cfg_mskb, cfg_vbi,
    output tcam_dst_id,
    input  req_ready, cfg_ready,
    input  tcam_mode, tcam_pkt_id, tcam_addr, tcam_data, tcam_mskb, tcam_vbi, tcam_vbe, tcam_dcs,
    input  rsp_valid, rsp_port, rsp_dst, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requesting port strictly after ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic             found;
  logic [IDX_W-1:0] k;

  // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

endmodule

// File: rtl/tcam_lookup_arbiter.sv
// Shares one TCAM controller between round-robin lookup requesters and a config port that drains
// in-flight compares first and is burst-limited so lookups cannot starve.
module tcam_lookup_arbiter
  import tcam_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 4,
  parameter int ADDR_W        = 4,
  parameter int BITS          = 8,
  parameter int RESULT_LAT    = 4,
  parameter int CMP_OCC       = 2,
  parameter int MAX_CFG_BURST = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  tcam_lookup_arbiter_if.slave bus
);

  localparam int PORT_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BURST_W = $clog2(MAX_CFG_BURST + 1);
  localparam int OCC_W   = (CMP_OCC > 2) ? $clog2(CMP_OCC - 1) : 1;

  state_e                state_q, state_d;
  logic [PORT_W-1:0]     ptr_q, ptr_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [RESULT_LAT-1:0] tag_valid;
  logic [PORT_W-1:0]     tag_port [RESULT_LAT];
  logic [ID_W-1:0]       req_id_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    grant;
  logic [PORT_W-1:0]     grant_idx;
  logic                  issue_cmp;
  logic                  any_req;
  logic                  pipe_empty;
  logic                  drain_done;
  logic                  burst_ok;
  logic                  rsp_fire;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_id_arr[k] = bus.req_id[k*ID_W +: ID_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (PORT_W)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign any_req    = |bus.req_valid;
  assign pipe_empty = ~|tag_valid;
  // Only the oldest tag left means the pipe is empty next cycle, so config can issue right then.
  assign drain_done = ~|tag_valid[RESULT_LAT-2:0];
  assign burst_ok   = burst_q < BURST_W'(MAX_CFG_BURST);

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    burst_d         = burst_q;
    occ_d           = occ_q;
    issue_cmp       = 1'b0;
    bus.req_ready   = '0;
    bus.cfg_ready   = 1'b0;
    bus.tcam_mode   = rst_n ? MODE_I : MODE_RST;
    bus.tcam_pkt_id = '0;
    bus.tcam_addr   = '0;
    bus.tcam_data   = '0;
    bus.tcam_mskb   = '0;
    bus.tcam_vbi    = 1'b0;
    bus.tcam_vbe    = 1'b0;
    bus.tcam_dcs    = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.cfg_valid && pipe_empty && (burst_ok || !any_req)) begin
            bus.cfg_ready = 1'b1;
            burst_d       = any_req ? burst_q + 1'b1 : '0;
            if (bus.cfg_op == CFG_WRITE) begin
              bus.tcam_mode = MODE_W;
              bus.tcam_addr = bus.cfg_addr;
              bus.tcam_data = bus.cfg_data;
              bus.tcam_mskb = bus.cfg_mskb;
              bus.tcam_vbi  = bus.cfg_vbi;
              bus.tcam_vbe  = 1'b1;
              bus.tcam_dcs  = 1'b1;
            end else begin
              bus.tcam_mode = MODE_F;
            end
          end else if (bus.cfg_valid && !pipe_empty && burst_ok) begin
            state_d = ST_DRAIN;
          end else if (any_req) begin
            issue_cmp       = 1'b1;
            bus.req_ready   = grant;
            bus.tcam_mode   = MODE_C;
            bus.tcam_pkt_id = req_id_arr[grant_idx];
            ptr_d           = grant_idx;
            burst_d         = '0;
            occ_d           = '0;
            state_d         = ST_CMP_WAIT;
          end
        end
        ST_CMP_WAIT: begin
          if (occ_q == OCC_W'(CMP_OCC - 2)) state_d = ST_IDLE;
          else                              occ_d   = occ_q + 1'b1;
        end
        ST_DRAIN: begin
          if (drain_done) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= PORT_W'(NUM_REQ - 1);
      burst_q   <= '0;
      occ_q     <= '0;
      tag_valid <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      occ_q     <= occ_d;
      tag_valid <= {tag_valid[RESULT_LAT-2:0], issue_cmp};
    end
  end

  // NOTE: tag ports are payload qualified by tag_valid, so this storage needs no reset.
  always_ff @(posedge clk) begin
    tag_port[0] <= grant_idx;
    for (int i = 1; i < RESULT_LAT; i++) tag_port[i] <= tag_port[i-1];
  end

  assign rsp_fire      = rst_n & tag_valid[RESULT_LAT-1];
  assign bus.rsp_valid = rsp_fire;
  assign bus.rsp_port  = rsp_fire ? tag_port[RESULT_LAT-1] : '0;
  assign bus.rsp_dst   = rsp_fire ? bus.tcam_dst_id : '0;
  assign bus.busy      = rst_n & (~pipe_empty | bus.cfg_valid);

endmodule

// File: tb/tb_tcam_lookup_arbiter.sv
// Scoreboard bench: accepted lookups queue their expected response, a TCAM model returns the result on time.
module tb_tcam_lookup_arbiter;
  import tcam_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 4;
  localparam int ADDR_W  = 4;
  localparam int BITS    = 8;
  localparam int LAT     = 4;

  typedef struct {
    int         due;
    logic [1:0] port;
    logic [3:0] dst;
  } exp_t;

  typedef struct {
    int         due;
    logic [3:0] dst;
  } tc_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb [$];
  tc_t  tq [$];
  logic [3:0] tbl [16];

  tcam_lookup_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .BITS(BITS)) bus ();

  tcam_lookup_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .ADDR_W(ADDR_W), .BITS(BITS),
    .RESULT_LAT(LAT), .CMP_OCC(2), .MAX_CFG_BURST(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // TCAM result model: drives the destination scheduled for this cycle, noise otherwise.
  initial begin
    bus.tcam_dst_id = '0;
    forever begin
      @(posedge clk);
      #1;
      while (tq.size() > 0 && tq[0].due < cyc) void'(tq.pop_front());
      if (tq.size() > 0 && tq[0].due == cyc) begin
        bus.tcam_dst_id = tq[0].dst;
        void'(tq.pop_front());
      end else begin
        bus.tcam_dst_id = 4'($urandom_range(0, 15));
      end
    end
  end

  // Monitor: checks every compare issue and every response slot against the scoreboard.
  initial begin : monitor
    int         last_cmp;
    int         k;
    logic       exp_v;
    logic [3:0] id;
    last_cmp = -100;
    forever begin
      @(negedge clk);
      exp_v = (sb.size() > 0) && (sb[0].due == cyc);
      checks++;
      if (bus.rsp_valid !== exp_v) begin
        failures++;
        $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp_valid, exp_v);
      end else if (exp_v) begin
        checks++;
        if (bus.rsp_port !== sb[0].port || bus.rsp_dst !== sb[0].dst) begin
          failures++;
          $display("FAIL rsp_payload cyc=%0d got port=%0d dst=%h exp port=%0d dst=%h",
                   cyc, bus.rsp_port, bus.rsp_dst, sb[0].port, sb[0].dst);
        end
      end
      if (exp_v) void'(sb.pop_front());

      if (bus.req_ready !== '0) begin
        k = 0;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i] === 1'b1) k = i;
        checks++;
        if ($countones(bus.req_ready) != 1 || (bus.req_ready & ~bus.req_valid) != '0 ||
            bus.tcam_mode !== MODE_C || (cyc - last_cmp) < 2) begin
          failures++;
          $display("FAIL cmp_issue cyc=%0d got ready=%b valid=%b mode=%0d gap=%0d exp onehot C gap>=2",
                   cyc, bus.req_ready, bus.req_valid, bus.tcam_mode, cyc - last_cmp);
        end
        id = bus.req_id[k*ID_W +: ID_W];
        checks++;
        if (bus.tcam_pkt_id !== id) begin
          failures++;
          $display("FAIL cmp_pkt_id cyc=%0d got=%h exp=%h", cyc, bus.tcam_pkt_id, id);
        end
        sb.push_back('{due: cyc + LAT, port: 2'(k), dst: tbl[id]});
        tq.push_back('{due: cyc + LAT, dst: tbl[id]});
        last_cmp = cyc;
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_id    = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_op    = CFG_WRITE;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.cfg_mskb  = '0;
    bus.cfg_vbi   = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      next_cycle();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d exp=0", sb.size());
      sb.delete();
      tq.delete();
    end
    next_cycle();
    next_cycle();
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    idle_inputs();
    sb.delete();
    tq.delete();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (bus.tcam_mode !== MODE_RST) begin
        failures++;
        $display("FAIL reset_mode cyc=%0d got=%0d exp=%0d", cyc, bus.tcam_mode, MODE_RST);
      end
      next_cycle();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_id    = 16'h4321;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.tcam_mode !== MODE_RST) begin
        failures++;
        $display("FAIL reset_mode got=%0d exp=%0d", bus.tcam_mode, MODE_RST);
      end
      checks++;
      if ({bus.req_ready, bus.cfg_ready, bus.busy, bus.tcam_pkt_id, bus.tcam_data, bus.tcam_vbe} !== '0) begin
        failures++;
        $display("FAIL reset_outputs got ready=%b cfg_ready=%b busy=%b pkt=%h data=%h exp all 0",
                 bus.req_ready, bus.cfg_ready, bus.busy, bus.tcam_pkt_id, bus.tcam_data);
      end
      next_cycle();
    end
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.tcam_mode !== MODE_I || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_idle got mode=%0d busy=%b exp mode=0 busy=0", bus.tcam_mode, bus.busy);
    end
    next_cycle();
  endtask

  task automatic test_single_lookup();
    bus.req_valid = 4'b0100;
    bus.req_id    = 16'h0500;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100 || bus.tcam_pkt_id !== 4'h5) begin
      failures++;
      $display("FAIL single_grant got ready=%b pkt=%h exp ready=0100 pkt=5", bus.req_ready, bus.tcam_pkt_id);
    end
    next_cycle();
    idle_inputs();
    wait_drain(10);
  endtask

  // From a freshly reset pointer all four ports win in order 0..3 every CMP_OCC cycles.
  task automatic run_all_ports();
    logic [3:0] pend;
    logic [3:0] exp;
    pend       = 4'hF;
    bus.req_id = 16'h73E1;
    for (int c = 0; c < 8; c++) begin
      bus.req_valid = pend;
      @(negedge clk);
      exp = (c % 2 == 0) ? 4'(1 << (c / 2)) : 4'b0000;
      checks++;
      if (bus.req_ready !== exp) begin
        failures++;
        $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.req_ready, exp);
      end
      pend = pend & ~bus.req_ready;
      next_cycle();
    end
    idle_inputs();
    wait_drain(20);
  endtask

  task automatic test_round_robin();
    apply_reset(1);
    run_all_ports();
  endtask

  task automatic test_cfg_drain();
    bus.req_valid = 4'b0001;
    bus.req_id    = 16'h0002;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL drain_first_lookup got=%b exp=0001", bus.req_ready);
    end
    next_cycle();
    bus.req_valid = 4'b0010;
    bus.req_id    = 16'h00B0;
    bus.cfg_valid = 1'b1;
    bus.cfg_op    = CFG_WRITE;
    bus.cfg_addr  = 4'h3;
    bus.cfg_data  = 8'hA0;
    bus.cfg_mskb  = 8'hF0;
    bus.cfg_vbi   = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if (bus.req_ready !== '0 || bus.cfg_ready !== 1'b0 || bus.tcam_mode !== MODE_I || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL drain_hold c=%0d got ready=%b cfg_ready=%b mode=%0d busy=%b exp 0000 0 0 1",
                 c, bus.req_ready, bus.cfg_ready, bus.tcam_mode, bus.busy);
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (bus.cfg_ready !== 1'b1 || bus.req_ready !== '0 ||
        {bus.tcam_mode, bus.tcam_addr, bus.tcam_data, bus.tcam_mskb, bus.tcam_vbi, bus.tcam_vbe, bus.tcam_dcs}
        !== {MODE_W, 4'h3, 8'hA0, 8'hF0, 3'b111}) begin
      failures++;
      $display("FAIL cfg_write got cfg_ready=%b mode=%0d addr=%h data=%h mskb=%h vbi/vbe/dcs=%b%b%b exp 1 W 3 A0 F0 111",
               bus.cfg_ready, bus.tcam_mode, bus.tcam_addr, bus.tcam_data, bus.tcam_mskb,
               bus.tcam_vbi, bus.tcam_vbe, bus.tcam_dcs);
    end
    next_cycle();
    bus.cfg_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL lookup_after_cfg got=%b exp=0010", bus.req_ready);
    end
    next_cycle();
    idle_inputs();
    wait_drain(10);
  endtask

  task automatic test_cfg_burst();
    int   ev [11];
    int   cfg_left;
    logic p1;
    logic exp_cfg;
    logic [3:0] exp_req;
    ev           = '{1, 1, 1, 1, 2, 0, 0, 0, 0, 1, 1};
    cfg_left     = 6;
    p1           = 1'b1;
    bus.cfg_op   = CFG_FLUSH;
    bus.cfg_addr = 4'h9;
    bus.cfg_data = 8'h5A;
    bus.cfg_mskb = 8'hFF;
    bus.cfg_vbi  = 1'b1;
    bus.req_id   = 16'h0060;
    for (int c = 0; c < 11; c++) begin
      bus.cfg_valid = (cfg_left > 0);
      bus.req_valid = {2'b00, p1, 1'b0};
      @(negedge clk);
      exp_cfg = (ev[c] == 1);
      exp_req = (ev[c] == 2) ? 4'b0010 : 4'b0000;
      checks++;
      if (bus.cfg_ready !== exp_cfg || bus.req_ready !== exp_req) begin
        failures++;
        $display("FAIL burst_seq c=%0d got cfg_ready=%b ready=%b exp cfg_ready=%b ready=%b",
                 c, bus.cfg_ready, bus.req_ready, exp_cfg, exp_req);
      end
      if (exp_cfg) begin
        checks++;
        if ({bus.tcam_mode, bus.tcam_addr, bus.tcam_data, bus.tcam_mskb, bus.tcam_vbi, bus.tcam_vbe, bus.tcam_dcs}
            !== {MODE_F, 4'h0, 8'h00, 8'h00, 3'b000}) begin
          failures++;
          $display("FAIL flush_fields c=%0d got mode=%0d addr=%h data=%h mskb=%h exp F with zero fields",
                   c, bus.tcam_mode, bus.tcam_addr, bus.tcam_data, bus.tcam_mskb);
        end
      end
      if (bus.cfg_ready === 1'b1) cfg_left--;
      if (bus.req_ready[1] === 1'b1) p1 = 1'b0;
      next_cycle();
    end
    idle_inputs();
    wait_drain(10);
  endtask

  task automatic test_miss();
    bus.req_valid = 4'b1000;
    bus.req_id    = 16'hC000;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL miss_grant got=%b exp=1000", bus.req_ready);
    end
    next_cycle();
    idle_inputs();
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_dst !== 4'h0 || bus.rsp_port !== 2'd3) begin
      failures++;
      $display("FAIL miss_rsp got valid=%b port=%0d dst=%h exp 1 3 0", bus.rsp_valid, bus.rsp_port, bus.rsp_dst);
    end
    next_cycle();
    wait_drain(5);
  endtask

  task automatic test_reset_midflight();
    bus.req_valid = 4'b0100;
    bus.req_id    = 16'h0500;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL midflight_grant got=%b exp=0100", bus.req_ready);
    end
    next_cycle();
    idle_inputs();
    next_cycle();
    apply_reset(2);
    run_all_ports();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = 4'(i) ^ 4'hC;
    idle_inputs();
    next_cycle();

    test_reset();
    test_single_lookup();
    test_round_robin();
    test_cfg_drain();
    test_cfg_burst();
    test_miss();
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tcam_lookup_arbiter.md
Name: tcam_lookup_arbiter

Overview:
- Shares one TCAM lookup controller between NUM_REQ packet-lookup requesters and one configuration port (write/flush).
- Lookups are granted round-robin and issued as one-cycle compare commands. Each in-flight lookup is tagged, and the destination ID is routed back to the originating port after a fixed latency.
- Config operations have priority but first drain in-flight lookups. A burst limit prevents lookup starvation.

Parameters:
- NUM_REQ, 4, number of lookup requesters
- ID_W, 4, packet/destination ID width
- ADDR_W, 4, TCAM address width
- BITS, 8, TCAM word width (2*ID_W)
- RESULT_LAT, 4, cycles from compare issue to valid tcam_dst_id
- CMP_OCC, 2, cycles a compare occupies the controller (issue + CMP_RD)
- MAX_CFG_BURST, 4, consecutive cfg grants allowed while any lookup is pending

Ports:
- clk in 1 clock
- rst_n in 1 synchronous active-low reset
- req_valid in NUM_REQ per-port lookup request
- req_ready out NUM_REQ per-port accept, one-hot or zero
- req_id in NUM_REQ*ID_W packet ID per port; port k is bits [k*ID_W +: ID_W]
- cfg_valid in 1 config request
- cfg_ready out 1 config accept
- cfg_op in 1 0=write, 1=flush
- cfg_addr in ADDR_W write address
- cfg_data in BITS write data
- cfg_mskb in BITS write mask bits
- cfg_vbi in 1 write valid bit
- tcam_mode out 3 mode command to TCAM controller
- tcam_pkt_id out ID_W compare key
- tcam_addr out ADDR_W
- tcam_data out BITS
- tcam_mskb out BITS
- tcam_vbi out 1
- tcam_vbe out 1
- tcam_dcs out 1
- tcam_dst_id in ID_W lookup result (0 = miss)
- rsp_valid out 1 result pulse
- rsp_port out $clog2(NUM_REQ) originating port
- rsp_dst out ID_W destination ID
- busy out 1 any lookup in flight or cfg pending

Behaviour:
- Reset:
  - rst_n is synchronous, active-low; clock is clk.
  - While rst_n=0, tcam_mode=RST (3'b101). All other outputs are 0.
  - The tag pipeline is cleared and any pending responses are dropped (no rsp_valid).
  - The round-robin pointer resets to NUM_REQ-1, so port 0 wins first. The burst counter resets to 0.
- Mode encoding: I=000, W=001, R=010, F=011, C=100, RST=101. tcam_mode=I in every cycle without an issue.
- Handshake:
  - A transfer occurs when valid&&ready in the same cycle.
  - Ready is combinational from the grant decision and asserted only in the issue cycle.
  - Requesters hold valid and payload stable until accepted. Withdrawing valid before acceptance is illegal.
- FSM states:
  - IDLE: select a grant.
  - CMP_WAIT: count CMP_OCC-1 cycles, then return to IDLE.
  - DRAIN: cfg pending; wait until the tag pipeline is empty.
- Grant in IDLE, in priority order:
  1. If cfg_valid and the pipeline is empty and (burst<MAX_CFG_BURST or no req_valid): issue cfg. Stay in IDLE; back-to-back cfg is allowed every cycle. Burst increments only if any req_valid, otherwise it clears.
  2. Else if cfg_valid and the pipeline is non-empty and burst<MAX_CFG_BURST: go to DRAIN. No new lookups are issued.
  3. Else if any req_valid: grant the first valid port after the RR pointer (wrapping), issue the compare, set pointer=granted, clear burst, go to CMP_WAIT.
- DRAIN → IDLE in the cycle after the pipeline is empty.
- Compare issue cycle t:
  - tcam_mode=C, tcam_pkt_id=req_id[granted], addr/data/mskb=0.
  - A tag {valid, port} enters a RESULT_LAT-deep shift register.
- Response:
  - At t+RESULT_LAT: rsp_valid=1, rsp_port=tag port, rsp_dst=tcam_dst_id sampled that cycle. A miss yields rsp_dst=0.
  - Responses have no backpressure. Ordering is issue order.
- Cfg write issue: tcam_mode=W, addr/data/mskb/vbi from the cfg port, vbe=1, dcs=1.
- Cfg flush issue: tcam_mode=F, data fields 0.
- Minimum spacing between compare issues is CMP_OCC cycles. A lookup may follow a cfg in the next cycle.
- Reset mid-flight: responses for lookups issued before reset never appear.

Decomposition:
- Package tcam_pkg: the mode localparams (I/W/R/F/C/RST), the cfg_op encoding, and the FSM state typedef.
- Sub-module rr_arbiter (NUM_REQ): takes the request vector and pointer, returns a one-hot grant and a binary index. It is purely combinational; the pointer register lives in the parent.

Test Plan:
- Single lookup: port 2 req_id=4'h5 at cycle 10, tcam_dst_id=4'h9 at cycle 14 → req_ready[2] high at cycle 10, tcam_mode=C with pkt_id=5 at cycle 10, rsp_valid with port=2, dst=9 at cycle 14.
- All 4 ports valid from cycle 0 → grants in order 0,1,2,3 at cycles 0,2,4,6; responses at 4,6,8,10 with matching ports.
- Cfg write (addr=3, data=8'hA0, mskb=8'hF0) raised at cycle 1, one cycle after a lookup issued at cycle 0 → no compare issued in cycles 1-4; W issued at cycle 5 after the cycle-4 response; lookup resumes at cycle 6.
- cfg_valid held continuously for 6 ops while port 1 is valid → 4 cfg issues, then one compare for port 1, then the cfg burst resumes.
- Miss: tcam_dst_id=0 at the response cycle → rsp_valid=1, rsp_dst=0.
- rst_n low for 2 cycles, 2 cycles after a compare issue → tcam_mode=RST during reset; no rsp_valid ever appears for that lookup; port 0 wins first after reset.
